// File: rtl/fifo_wr_arb_pkg.sv
// Shared helpers for the FIFO write-side arbiter.
package fifo_wr_arb_pkg;

   // Larger of two widths; sizes the length-versus-space comparison.
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: the first requester at or after rr, with wrap.
module fifo_rr_pick #(
   parameter int ID_BITS = 2
) (
   input  logic [(1<<ID_BITS)-1:0] req,
   input  logic [ID_BITS-1:0]      rr,
   output logic                    found,
   output logic [ID_BITS-1:0]      idx
);

   localparam int N_REQ = 1 << ID_BITS;

   logic [ID_BITS-1:0] probe;

   // Walk the requesters from rr upward; the ID_BITS-wide sum wraps naturally.
   always_comb begin
      // NOTE: every output gets a default first, so no path through the loop leaves one unassigned (no latch).
      found = 1'b0;
      idx   = '0;
      probe = '0;
      for (int k = 0; k < N_REQ; k++) begin
         probe = rr + ID_BITS'(k);
         if (!found && req[probe]) begin
            found = 1'b1;
            idx   = probe;
         end
      end
   end

endmodule

// File: rtl/fifo_wr_arb.sv
// Write-side arbiter: shares one FIFO write port among 2^ID_BITS requesters.
// A burst is granted only when the FIFO already has room for every word of it,
// so bursts are atomic and never stall on full.
module fifo_wr_arb
   import fifo_wr_arb_pkg::*;
#(
   parameter int ID_BITS   = 2,
   parameter int DATA_BITS = 32,
   parameter int ADDR_BITS = 8,
   parameter int LEN_BITS  = 4
) (
   input  logic                                clk_w,
   input  logic                                rst,
   input  logic [(1<<ID_BITS)-1:0]             req,
   input  logic [(1<<ID_BITS)*LEN_BITS-1:0]    req_len,
   input  logic [(1<<ID_BITS)-1:0]             req_valid,
   input  logic [(1<<ID_BITS)*DATA_BITS-1:0]   req_data,
   output logic [(1<<ID_BITS)-1:0]             gnt,
   output logic [(1<<ID_BITS)-1:0]             ack,
   output logic [(1<<ID_BITS)-1:0]             done,
   output logic                                busy,
   output logic [ID_BITS-1:0]                  cur_id,
   output logic                                fifo_en_w,
   output logic [DATA_BITS-1:0]                fifo_data_w,
   input  logic                                fifo_full_w,
   input  logic [ADDR_BITS-1:0]                fifo_space_count
);

   localparam int N_REQ    = 1 << ID_BITS;
   // Wide enough for req_len+1 without overflow and for the whole space count.
   localparam int CMP_BITS = max_int(LEN_BITS + 1, ADDR_BITS);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   logic [0:0]          state;
   logic [LEN_BITS-1:0] cnt;   // words still owed after the current one
   logic [ID_BITS-1:0]  rr;    // search start for the next grant

   logic                cand_found;
   logic [ID_BITS-1:0]  cand_id;
   logic [LEN_BITS-1:0] cand_len;
   logic                cand_fit;
   logic                wr;
   logic                last;

   fifo_rr_pick #(
      .ID_BITS (ID_BITS)
   ) u_pick (
      .req   (req),
      .rr    (rr),
      .found (cand_found),
      .idx   (cand_id)
   );

   assign cand_len = req_len[cand_id*LEN_BITS +: LEN_BITS];
   // Whole burst must fit now; space only grows from reads while we own the port.
   assign cand_fit = (CMP_BITS'(cand_len) + CMP_BITS'(1)) <= CMP_BITS'(fifo_space_count);

   assign busy        = |gnt;
   assign wr          = busy & req_valid[cur_id] & ~fifo_full_w & ~rst;
   assign last        = wr & (cnt == '0);
   assign fifo_en_w   = wr;
   assign ack         = wr ? gnt : '0;
   assign done        = last ? gnt : '0;
   assign fifo_data_w = busy ? req_data[cur_id*DATA_BITS +: DATA_BITS] : '0;

   // Burst FSM: grant the round-robin candidate only if it fits, then count its words out.
   always_ff @(posedge clk_w) begin
      // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
      if (rst) begin
         state  <= ST_IDLE;
         gnt    <= '0;
         cnt    <= '0;
         rr     <= '0;
         cur_id <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // No bypass: a candidate that does not fit blocks everyone behind it.
               if (cand_found && cand_fit) begin
                  state  <= ST_BURST;
                  cur_id <= cand_id;
                  cnt    <= cand_len;
                  gnt    <= N_REQ'(1) << cand_id;
               end
            end
            ST_BURST: begin
               if (wr) begin
                  if (cnt == '0) begin
                     state <= ST_IDLE;
                     gnt   <= '0;
                     rr    <= cur_id + 1'b1;
                  end else begin
                     cnt <= cnt - 1'b1;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb, plus a run against a small behavioural FIFO.
module tb_fifo_wr_arb;

   localparam int ID_BITS   = 2;
   localparam int N_REQ     = 4;
   localparam int DATA_BITS = 32;
   localparam int ADDR_BITS = 8;
   localparam int LEN_BITS  = 4;
   localparam int CAP       = 20;   // capacity of the behavioural FIFO

   logic         clk_w = 1'b0;
   logic         rst;
   logic [3:0]   req;
   logic [15:0]  req_len;
   logic [3:0]   req_valid;
   logic [127:0] req_data;
   logic [3:0]   gnt;
   logic [3:0]   ack;
   logic [3:0]   done;
   logic         busy;
   logic [1:0]   cur_id;
   logic         fifo_en_w;
   logic [31:0]  fifo_data_w;
   logic         fifo_full_w;
   logic [7:0]   fifo_space_count;

   // Directed sources versus behavioural-FIFO sources.
   logic         use_model;
   logic [127:0] dir_data;
   logic [7:0]   dir_space;
   logic         dir_full;
   logic [127:0] gen_data;
   logic [23:0]  wcnt [4];

   // Behavioural FIFO with a reader popping every third cycle.
   logic [31:0]  mem [32];
   logic [31:0]  rd_log [512];
   int           wp, rp, count, rd_div, rd_n;
   int           viol = 0;

   int           n_chk  = 0;
   int           n_pass = 0;

   always #5 clk_w = ~clk_w;

   fifo_wr_arb #(
      .ID_BITS   (ID_BITS),
      .DATA_BITS (DATA_BITS),
      .ADDR_BITS (ADDR_BITS),
      .LEN_BITS  (LEN_BITS)
   ) dut (
      .clk_w            (clk_w),
      .rst              (rst),
      .req              (req),
      .req_len          (req_len),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .gnt              (gnt),
      .ack              (ack),
      .done             (done),
      .busy             (busy),
      .cur_id           (cur_id),
      .fifo_en_w        (fifo_en_w),
      .fifo_data_w      (fifo_data_w),
      .fifo_full_w      (fifo_full_w),
      .fifo_space_count (fifo_space_count)
   );

   // Each generated word carries its requester id and a per-requester sequence number.
   always_comb begin
      gen_data = '0;
      for (int i = 0; i < N_REQ; i++) gen_data[i*32 +: 32] = {8'(i), wcnt[i]};
   end

   always_comb begin
      req_data         = use_model ? gen_data : dir_data;
      fifo_space_count = use_model ? 8'(CAP - count) : dir_space;
      fifo_full_w      = use_model ? (count == CAP) : dir_full;
   end

   always @(posedge clk_w) begin
      if (rst) begin
         wp     <= 0;
         rp     <= 0;
         count  <= 0;
         rd_div <= 0;
         rd_n   <= 0;
         for (int i = 0; i < N_REQ; i++) wcnt[i] <= '0;
      end else if (use_model) begin
         rd_div <= (rd_div == 2) ? 0 : rd_div + 1;
         if (fifo_en_w) begin
            mem[wp] <= fifo_data_w;
            wp      <= (wp + 1) % 32;
         end
         if (rd_div == 2 && count > 0 && rd_n < 512) begin
            rd_log[rd_n] <= mem[rp];
            rd_n         <= rd_n + 1;
            rp           <= (rp + 1) % 32;
         end
         count <= count + (fifo_en_w ? 1 : 0) - ((rd_div == 2 && count > 0 && rd_n < 512) ? 1 : 0);
         for (int i = 0; i < N_REQ; i++) if (ack[i]) wcnt[i] <= wcnt[i] + 1'b1;
      end
   end

   always @(negedge clk_w) begin
      #3;
      if (use_model && fifo_en_w && fifo_full_w) viol <= viol + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic set_len(input int id, input logic [3:0] v);
      req_len[id*4 +: 4] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk_w);
      rst = 1'b0;
   endtask

   // Drive and check one owned burst, starting in its first granted cycle.
   task automatic burst(input int id, input int words, input logic [31:0] base);
      for (int k = 0; k < words; k++) begin
         dir_data[id*32 +: 32] = base + 32'(k);
         #1;
         check("burst_en",   fifo_en_w,   64'd1);
         check("burst_gnt",  gnt,         64'(1) << id);
         check("burst_ack",  ack,         64'(1) << id);
         check("burst_done", done,        (k == words - 1) ? (64'(1) << id) : 64'd0);
         check("burst_data", fifo_data_w, base + 32'(k));
         @(negedge clk_w);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int order [5] = '{0, 1, 2, 3, 0};
      int lens  [4] = '{5, 2, 7, 11};
      int exp_seq [4];
      int i, id, run;
      logic [23:0] total;

      rst = 1'b1; req = '0; req_valid = '0; req_len = '0;
      dir_data = '0; dir_space = '0; dir_full = 1'b0; use_model = 1'b0;

      // Reset state.
      @(negedge clk_w); #1;
      check("rst_gnt",   gnt,         64'd0);
      check("rst_busy",  busy,        64'd0);
      check("rst_curid", cur_id,      64'd0);
      check("rst_ack",   ack,         64'd0);
      check("rst_done",  done,        64'd0);
      check("rst_en",    fifo_en_w,   64'd0);
      check("rst_data",  fifo_data_w, 64'd0);
      rst = 1'b0;

      // Single burst; no grant while the FIFO reports zero space.
      req = 4'b0010; set_len(1, 4'd3); req_valid = 4'b0010;
      @(negedge clk_w); #1;
      check("nospace_gnt", gnt, 64'd0);
      dir_space = 8'd255;
      @(negedge clk_w); #1;
      check("t1_gnt",   gnt,     64'b0010);
      check("t1_cnt",   dut.cnt, 64'd3);
      check("t1_curid", cur_id,  64'd1);
      burst(1, 4, 32'hA0);
      #1;
      check("t1_end_gnt",   gnt,       64'd0);
      check("t1_end_busy",  busy,      64'd0);
      check("t1_end_en",    fifo_en_w, 64'd0);
      check("t1_end_rr",    dut.rr,    64'd2);
      check("t1_end_curid", cur_id,    64'd1);
      req = '0; req_valid = '0;

      // Round-robin, all single-word bursts, one idle cycle between grants.
      do_reset();
      for (int k = 0; k < N_REQ; k++) set_len(k, 4'd0);
      req = 4'b1111; req_valid = 4'b1111;
      for (int g = 0; g < 5; g++) begin
         @(negedge clk_w); #1;
         check("rr_gnt",  gnt,  64'(1) << order[g]);
         check("rr_done", done, 64'(1) << order[g]);
         @(negedge clk_w); #1;
         check("rr_idle", gnt, 64'd0);
      end
      req = '0; req_valid = '0;

      // Space gating without bypass.
      do_reset();
      set_len(0, 4'd15); set_len(2, 4'd0);
      req = 4'b0101; req_valid = 4'b0101; dir_space = 8'd10;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_w); #1;
         check("nobypass_gnt", gnt, 64'd0);
      end
      dir_space = 8'd15;
      @(negedge clk_w); #1;
      check("space15_gnt", gnt, 64'd0);
      dir_space = 8'd16;
      @(negedge clk_w); #1;
      check("space16_gnt", gnt, 64'b0001);
      burst(0, 16, 32'hB00);
      #1;
      check("gate_idle", gnt,    64'd0);
      check("gate_rr",   dut.rr, 64'd1);
      @(negedge clk_w); #1;
      check("gate_gnt2", gnt, 64'b0100);
      burst(2, 1, 32'hC0);
      req = '0; req_valid = '0; dir_space = 8'd255;

      // Stall and drop: len=2 burst with a 3-cycle valid gap, then a full cycle.
      set_len(3, 4'd2); req = 4'b1000; req_valid = 4'b1000;
      @(negedge clk_w); #1;
      check("stall_gnt", gnt, 64'b1000);
      dir_data[3*32 +: 32] = 32'hD0;
      #1;
      check("stall_w0_en",   fifo_en_w, 64'd1);
      check("stall_w0_done", done,      64'd0);
      @(negedge clk_w);
      req = '0; req_valid = '0;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("gap_en",  fifo_en_w, 64'd0);
         check("gap_ack", ack,       64'd0);
         check("gap_gnt", gnt,       64'b1000);
         @(negedge clk_w);
      end
      req_valid = 4'b1000; dir_full = 1'b1;
      #1;
      check("full_en",   fifo_en_w, 64'd0);
      check("full_ack",  ack,       64'd0);
      check("full_done", done,      64'd0);
      @(negedge clk_w);
      dir_full = 1'b0;
      burst(3, 2, 32'hD1);
      #1;
      check("stall_end_gnt", gnt, 64'd0);
      @(negedge clk_w); #1;
      check("stall_no_regrant", gnt, 64'd0);
      req_valid = '0;

      // Mid-burst reset after 2 of 8 words.
      set_len(0, 4'd0); req = 4'b0001; req_valid = 4'b0001;
      @(negedge clk_w); #1;
      check("pre_gnt0", gnt, 64'b0001);
      burst(0, 1, 32'hE0);
      set_len(2, 4'd7); req = 4'b0100; req_valid = 4'b0100;
      @(negedge clk_w); #1;
      check("mid_gnt2", gnt, 64'b0100);
      for (int k = 0; k < 2; k++) begin
         dir_data[2*32 +: 32] = 32'hE8 + 32'(k);
         #1;
         check("mid_w_en",   fifo_en_w, 64'd1);
         check("mid_w_done", done,      64'd0);
         @(negedge clk_w);
      end
      rst = 1'b1;
      #1;
      check("rstcyc_en",   fifo_en_w, 64'd0);
      check("rstcyc_ack",  ack,       64'd0);
      check("rstcyc_done", done,      64'd0);
      @(negedge clk_w); #1;
      check("postrst_gnt",   gnt,     64'd0);
      check("postrst_busy",  busy,    64'd0);
      check("postrst_curid", cur_id,  64'd0);
      check("postrst_rr",    dut.rr,  64'd0);
      check("postrst_cnt",   dut.cnt, 64'd0);
      rst = 1'b0;
      req = 4'b0101; req_valid = 4'b0101;
      @(negedge clk_w); #1;
      check("postrst_first", gnt, 64'b0001);
      burst(0, 1, 32'hF0);
      @(negedge clk_w); #1;
      check("fresh_gnt", gnt,     64'b0100);
      check("fresh_cnt", dut.cnt, 64'd7);
      burst(2, 8, 32'h100);
      req = '0; req_valid = '0;

      // Integration with the behavioural FIFO and a slow reader.
      use_model = 1'b1;
      do_reset();
      for (int k = 0; k < N_REQ; k++) set_len(k, 4'(lens[k]));
      req = 4'b1111; req_valid = 4'b1111;
      for (int c = 0; c < 300; c++) @(negedge clk_w);
      req = '0;
      for (int c = 0; c < 200 && busy; c++) @(negedge clk_w);
      check("int_idle", busy, 64'd0);
      for (int c = 0; c < 600 && count != 0; c++) @(negedge clk_w);
      @(negedge clk_w);
      check("int_drained", count, 64'd0);
      check("int_no_full_write", viol, 64'd0);
      total = wcnt[0] + wcnt[1] + wcnt[2] + wcnt[3];
      check("int_total", rd_n, 64'(total));
      check("int_enough", (rd_n > 20), 64'd1);
      for (int k = 0; k < N_REQ; k++) exp_seq[k] = 0;
      i = 0;
      while (i < rd_n) begin
         id  = int'(rd_log[i][25:24]);
         run = 0;
         check("int_id_hi", rd_log[i][31:26], 64'd0);
         while (i < rd_n && int'(rd_log[i][25:24]) == id) begin
            check("int_seq", rd_log[i][23:0], 64'(exp_seq[id]));
            exp_seq[id]++;
            run++;
            i++;
         end
         check("int_run", run, 64'(lens[id] + 1));
      end
      req_valid = '0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
